// File: rtl/fnd_scan.sv
// Scanned 8-digit common-anode 7-segment driver with double-buffered display
// word, anti-ghosting blank on every address change and leading-zero blanking.
module fnd_scan #(
  parameter int DIGITS    = 8,
  parameter int ADDR_W    = 3,
  parameter int BLANK_CYC = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [4*DIGITS-1:0] data_in,
  input  logic [DIGITS-1:0]   dp_in,
  input  logic                load,
  input  logic                lz_en,
  output logic [DIGITS-1:0]   an,
  output logic [6:0]          seg,
  output logic                dp,
  output logic                frame_swap
);

  typedef enum logic {BLANK, DRIVE} state_t;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'h40;  4'h1: decode = 7'h79;
      4'h2: decode = 7'h24;  4'h3: decode = 7'h30;
      4'h4: decode = 7'h19;  4'h5: decode = 7'h12;
      4'h6: decode = 7'h02;  4'h7: decode = 7'h78;
      4'h8: decode = 7'h00;  4'h9: decode = 7'h10;
      4'hA: decode = 7'h08;  4'hB: decode = 7'h03;
      4'hC: decode = 7'h46;  4'hD: decode = 7'h21;
      4'hE: decode = 7'h06;  default: decode = 7'h0E;
    endcase
  endfunction

  logic [4*DIGITS-1:0] act_data, sh_data;
  logic [DIGITS-1:0]   act_dp, sh_dp;
  logic                pending;
  logic [ADDR_W-1:0]   addr_q;
  state_t              state;
  logic [3:0]          cnt;

  // upper_zero[i]: nibbles i..DIGITS-1 of the active word are all zero
  logic [DIGITS-1:0] upper_zero;
  genvar i;
  generate
    for (i = 0; i < DIGITS; i++) begin : g_lz
      assign upper_zero[i] = ~|act_data[4*DIGITS-1:4*i];
    end
  endgenerate

  logic              chg, swap, blank_dig;
  logic [3:0]        cur_nib;
  logic [DIGITS-1:0] an_sel;

  assign chg       = (addr != addr_q);
  assign swap      = chg && (addr == '0) && pending;
  assign cur_nib   = act_data[{addr_q, 2'b00} +: 4];
  assign blank_dig = lz_en && (addr_q != '0) && upper_zero[addr_q];
  assign an_sel    = ~(DIGITS'(1) << addr_q);

  always_ff @(posedge clk) begin
    if (!rst) begin
      act_data   <= '0;
      act_dp     <= '0;
      sh_data    <= '0;
      sh_dp      <= '0;
      pending    <= 1'b0;
      addr_q     <= '0;
      state      <= BLANK;
      cnt        <= 4'(BLANK_CYC - 1);
      an         <= '1;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_swap <= 1'b0;
    end else begin
      frame_swap <= swap;
      // swap reads the old shadow, so a load on the same edge stays pending
      if (swap) begin
        act_data <= sh_data;
        act_dp   <= sh_dp;
      end
      if (load) begin
        sh_data <= data_in;
        sh_dp   <= dp_in;
        pending <= 1'b1;
      end else if (swap) begin
        pending <= 1'b0;
      end

      if (chg) begin
        addr_q <= addr;
        state  <= BLANK;
        cnt    <= 4'(BLANK_CYC - 1);
        an     <= '1;
        seg    <= 7'h7F;
        dp     <= 1'b1;
      end else if (state == BLANK) begin
        if (cnt == 4'd0) begin
          state <= DRIVE;
          an    <= an_sel;
          seg   <= blank_dig ? 7'h7F : decode(cur_nib);
          dp    <= ~act_dp[addr_q];
        end else begin
          cnt <= cnt - 4'd1;
        end
      end
    end
  end

endmodule
